// File: rtl/div_ratio_arbiter_pkg.sv
// Shared types and helpers for the divide-ratio arbiter.
package div_arb_pkg;

    localparam int unsigned MAX_REQ  = 8;
    localparam int unsigned IDX_W    = 3;
    localparam int unsigned DIV_ZERO = 0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARB,
        ST_WAIT_EDGE,
        ST_COMMIT,
        ST_SETTLE
    } state_t;

    typedef struct packed {
        logic             found;
        logic [IDX_W-1:0] idx;
    } rr_pick_t;

    // First set request at or after ptr, wrapping within the n live requesters.
    function automatic rr_pick_t rr_pick(input logic [MAX_REQ-1:0] req,
                                         input logic [IDX_W-1:0]   ptr,
                                         input int unsigned        n);
        rr_pick_t         res;
        logic [IDX_W-1:0] idx;
        res = '0;
        idx = '0;
        for (int unsigned i = 0; i < MAX_REQ; i++) begin
            idx = IDX_W'((32'(ptr) + i) % n);
            if ((i < n) && !res.found && req[idx]) begin
                res.found = 1'b1;
                res.idx   = idx;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/div_ratio_arbiter_if.sv
// Requester/divider-side bundle of the divide-ratio arbiter.
interface div_ratio_arbiter_if #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned WIDE  = 32
);
    logic [N_REQ-1:0]      i_Req;
    logic [N_REQ*WIDE-1:0] i_Div_Req;
    logic                  i_Div_Clk;
    logic [WIDE-1:0]       o_Div;
    logic [N_REQ-1:0]      o_Gnt;
    logic                  o_Busy;
    logic                  o_Timeout;
    logic                  o_Err;

    modport master (
        output i_Req, i_Div_Req, i_Div_Clk,
        input  o_Div, o_Gnt, o_Busy, o_Timeout, o_Err
    );

    modport slave (
        input  i_Req, i_Div_Req, i_Div_Clk,
        output o_Div, o_Gnt, o_Busy, o_Timeout, o_Err
    );
endinterface

// File: rtl/div_ratio_arbiter_edge_det.sv
// Synchronises the fed-back divided clock and emits a one-cycle rise pulse.
module div_clk_edge_det (
    input  logic i_Clk,
    input  logic i_Rst_n,
    input  logic i_Div_Clk,
    output logic o_Rise
);
    logic sync1_q;
    logic sync2_q;
    logic last_q;

    // Two-flop synchroniser, delay stage and registered rise detect.
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            last_q  <= 1'b0;
            o_Rise  <= 1'b0;
        end else begin
            sync1_q <= i_Div_Clk;
            sync2_q <= sync1_q;
            last_q  <= sync2_q;
            o_Rise  <= sync2_q & ~last_q;
        end
    end
endmodule

// File: rtl/div_ratio_arbiter.sv
// Round-robin arbiter that hands one shared clock divider its ratio,
// committing a change only just after a divided-clock rising edge.
module div_ratio_arbiter
    import div_arb_pkg::*;
#(
    parameter int unsigned N_REQ      = 4,
    parameter int unsigned WIDE       = 32,
    parameter int unsigned DEF_DIV    = 1,
    parameter int unsigned TIMEOUT    = 1 << 20,
    parameter int unsigned SETTLE_CYC = 4
) (
    input  logic                i_Clk,
    input  logic                i_Rst_n,
    div_ratio_arbiter_if.slave  bus
);
    localparam int unsigned PTR_W = $clog2(N_REQ);
    localparam int unsigned CNT_W = $clog2(TIMEOUT);
    localparam int unsigned SET_W = $clog2(SETTLE_CYC + 1);

    state_t           state_q, state_n;
    logic [PTR_W-1:0] sel_q, sel_n;
    logic [PTR_W-1:0] rr_q, rr_n;
    logic [WIDE-1:0]  new_div_q, new_div_n;
    logic [WIDE-1:0]  div_q, div_n;
    logic [CNT_W-1:0] tmo_cnt_q, tmo_cnt_n;
    logic [SET_W-1:0] set_cnt_q, set_cnt_n;
    logic [N_REQ-1:0] gnt_q, gnt_c;
    logic             err_q, err_c;
    logic             tmo_q, tmo_c;
    logic             busy_q;
    logic             div_rise;
    rr_pick_t         pick;
    logic [WIDE-1:0]  req_div;

    div_clk_edge_det u_edge (
        .i_Clk     (i_Clk),
        .i_Rst_n   (i_Rst_n),
        .i_Div_Clk (bus.i_Div_Clk),
        .o_Rise    (div_rise)
    );

    function automatic logic [PTR_W-1:0] ptr_after(input logic [PTR_W-1:0] s);
        if (32'(s) == N_REQ - 1) return '0;
        return s + PTR_W'(1);
    endfunction

    // State, latched selection and registered outputs.
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state_q   <= ST_IDLE;
            sel_q     <= '0;
            rr_q      <= '0;
            new_div_q <= '0;
            div_q     <= WIDE'(DEF_DIV);
            tmo_cnt_q <= '0;
            set_cnt_q <= '0;
            gnt_q     <= '0;
            err_q     <= 1'b0;
            tmo_q     <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_n;
            sel_q     <= sel_n;
            rr_q      <= rr_n;
            new_div_q <= new_div_n;
            div_q     <= div_n;
            tmo_cnt_q <= tmo_cnt_n;
            set_cnt_q <= set_cnt_n;
            gnt_q     <= gnt_c;
            err_q     <= err_c;
            tmo_q     <= tmo_c;
            busy_q    <= (state_n != ST_IDLE);
        end
    end

    // Arbitration, edge wait, commit and settle sequencing.
    always_comb begin
        state_n   = state_q;
        sel_n     = sel_q;
        rr_n      = rr_q;
        new_div_n = new_div_q;
        div_n     = div_q;
        tmo_cnt_n = tmo_cnt_q;
        set_cnt_n = set_cnt_q;
        gnt_c     = '0;
        err_c     = 1'b0;
        tmo_c     = 1'b0;
        pick      = rr_pick(MAX_REQ'(bus.i_Req), IDX_W'(rr_q), N_REQ);
        req_div   = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            if (IDX_W'(k) == pick.idx) req_div = bus.i_Div_Req[k*WIDE +: WIDE];
        end

        unique case (state_q)
            ST_IDLE: begin
                if (|bus.i_Req) state_n = ST_ARB;
            end
            ST_ARB: begin
                if (!pick.found) begin
                    state_n = ST_IDLE;
                end else begin
                    sel_n     = PTR_W'(pick.idx);
                    new_div_n = req_div;
                    if (req_div == WIDE'(DIV_ZERO)) begin
                        err_c     = 1'b1;
                        gnt_c     = N_REQ'(1) << pick.idx;
                        rr_n      = ptr_after(PTR_W'(pick.idx));
                        set_cnt_n = '0;
                        state_n   = ST_SETTLE;
                    end else if ((req_div == div_q) || (div_q == WIDE'(1))) begin
                        state_n = ST_COMMIT;
                    end else begin
                        tmo_cnt_n = '0;
                        state_n   = ST_WAIT_EDGE;
                    end
                end
            end
            ST_WAIT_EDGE: begin
                // A withdrawn request beats a coincident edge or timeout.
                if (!bus.i_Req[sel_q]) begin
                    state_n = ST_IDLE;
                end else if (div_rise) begin
                    state_n = ST_COMMIT;
                end else if (tmo_cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    tmo_c   = 1'b1;
                    state_n = ST_COMMIT;
                end else begin
                    tmo_cnt_n = tmo_cnt_q + CNT_W'(1);
                end
            end
            ST_COMMIT: begin
                div_n     = new_div_q;
                gnt_c     = N_REQ'(1) << sel_q;
                rr_n      = ptr_after(sel_q);
                set_cnt_n = '0;
                state_n   = ST_SETTLE;
            end
            ST_SETTLE: begin
                if (set_cnt_q == SET_W'(SETTLE_CYC - 1)) state_n = ST_IDLE;
                else                                      set_cnt_n = set_cnt_q + SET_W'(1);
            end
            default: state_n = ST_IDLE;
        endcase
    end

    assign bus.o_Div     = div_q;
    assign bus.o_Gnt     = gnt_q;
    assign bus.o_Busy    = busy_q;
    assign bus.o_Timeout = tmo_q;
    assign bus.o_Err     = err_q;
endmodule

// File: tb/tb_div_ratio_arbiter.sv
// Scoreboard bench for div_ratio_arbiter.
module tb_div_ratio_arbiter;
    localparam int unsigned N_REQ      = 4;
    localparam int unsigned WIDE       = 32;
    localparam int unsigned TIMEOUT    = 16;
    localparam int unsigned SETTLE_CYC = 4;

    typedef struct {
        logic [1:0]  idx;
        logic [31:0] div;
        bit          err;
        bit          tmo;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    int          cyc = 0;
    int          n_checks = 0;
    int          n_fail = 0;
    exp_t        exp_q[$];
    logic [31:0] ratios [4];
    logic [31:0] mdl_div;
    bit          div_run = 1'b0;
    int          div_ph = 0;
    int          last_rise = 0;
    int          last_gnt = 0;
    bit          have_last = 1'b0;
    bit          tmo_prev = 1'b0;

    div_ratio_arbiter_if #(.N_REQ(N_REQ), .WIDE(WIDE)) bus ();

    div_ratio_arbiter #(
        .N_REQ(N_REQ), .WIDE(WIDE), .DEF_DIV(1), .TIMEOUT(TIMEOUT), .SETTLE_CYC(SETTLE_CYC)
    ) u_dut (
        .i_Clk   (clk),
        .i_Rst_n (rst_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, want);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive_ratios();
        bus.i_Div_Req = {ratios[3], ratios[2], ratios[1], ratios[0]};
    endtask

    task automatic wait_idle(input string tag);
        for (int i = 0; i < 64 && bus.o_Busy; i++) tick(1);
        check({tag, "_idle"}, 64'(bus.o_Busy), 64'd0);
    endtask

    // Raise mask, expect a grant to k with the given outcome, then drop mask.
    task automatic serve(input string tag, input logic [3:0] mask, input logic [1:0] k,
                         input logic [31:0] ratio, input bit e_err, input bit e_tmo,
                         input int e_lat, input bit chk_rise);
        exp_t x;
        int   c0;
        bit   got;
        wait_idle(tag);
        ratios[k] = ratio;
        drive_ratios();
        x.idx = k;
        x.div = e_err ? mdl_div : ratio;
        x.err = e_err;
        x.tmo = e_tmo;
        mdl_div = x.div;
        exp_q.push_back(x);
        bus.i_Req = mask;
        c0  = cyc;
        got = 1'b0;
        for (int i = 0; i < int'(TIMEOUT) + 40 && !got; i++) begin
            @(negedge clk);
            if (|bus.o_Gnt) got = 1'b1;
        end
        check({tag, "_gnt_seen"}, 64'(got), 64'd1);
        if (got && e_lat >= 0) check({tag, "_lat"}, 64'(cyc - c0), 64'(e_lat));
        if (got && chk_rise)   check({tag, "_rise_lat"}, 64'(cyc - last_rise), 64'd5);
        @(posedge clk);
        #1;
        bus.i_Req = 4'b0000;
    endtask

    initial begin
        logic [38:0] rst_vec;
        rst_vec       = {32'd1, 7'd0};
        bus.i_Req     = '0;
        bus.i_Div_Req = '0;
        bus.i_Div_Clk = 1'b0;
        for (int i = 0; i < 4; i++) ratios[i] = 32'd0;
        mdl_div = 32'd1;

        // Grant monitor: pops the scoreboard on every o_Gnt pulse.
        fork
            forever begin
                @(negedge clk);
                if (rst_n) begin
                    if (|bus.o_Gnt) begin
                        if (exp_q.size() == 0) begin
                            check("gnt_unexpected", 64'(bus.o_Gnt), 64'd0);
                        end else begin
                            exp_t       e;
                            logic [3:0] oh;
                            e  = exp_q.pop_front();
                            oh = 4'(1) << e.idx;
                            check("gnt_vec",  64'(bus.o_Gnt),  64'(oh));
                            check("gnt_div",  64'(bus.o_Div),  64'(e.div));
                            check("gnt_err",  64'(bus.o_Err),  64'(e.err));
                            check("gnt_tmo",  64'(tmo_prev),   64'(e.tmo));
                            check("gnt_busy", 64'(bus.o_Busy), 64'd1);
                            if (have_last)
                                check("gnt_gap", 64'((cyc - last_gnt) > int'(SETTLE_CYC)), 64'd1);
                        end
                        last_gnt  = cyc;
                        have_last = 1'b1;
                    end else if (bus.o_Err) begin
                        check("err_without_gnt", 64'(bus.o_Err), 64'd0);
                    end
                    tmo_prev = bus.o_Timeout;
                end
            end
        join_none

        // Free-running divided clock, period 12 cycles, when enabled.
        fork
            forever begin
                @(posedge clk);
                #2;
                if (div_run) begin
                    div_ph++;
                    if (div_ph == 6) begin
                        div_ph = 0;
                        bus.i_Div_Clk = ~bus.i_Div_Clk;
                        if (bus.i_Div_Clk) last_rise = cyc;
                    end
                end
            end
        join_none

        tick(3);
        rst_n = 1'b1;

        // Idle after reset.
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            check("rst_idle", 64'({bus.o_Div, bus.o_Busy, bus.o_Gnt, bus.o_Timeout, bus.o_Err}),
                  64'(rst_vec));
        end
        tick(1);

        // Bypass fast path.
        serve("t2_bypass", 4'b0001, 2'd0, 32'd5, 1'b0, 1'b0, 3, 1'b0);

        // Edge-aligned commit with divider running.
        div_ph  = 0;
        div_run = 1'b1;
        serve("t3_edge", 4'b0100, 2'd2, 32'd7, 1'b0, 1'b0, -1, 1'b1);

        // Same ratio as current: fast path, moves pointer to 0.
        serve("t3_same", 4'b1000, 2'd3, 32'd7, 1'b0, 1'b0, 3, 1'b0);

        // All four held: rotation 0,1,2,3,0.
        wait_idle("t4");
        ratios[0] = 32'd3; ratios[1] = 32'd5; ratios[2] = 32'd7; ratios[3] = 32'd9;
        drive_ratios();
        for (int i = 0; i < 5; i++) begin
            exp_t x;
            x.idx = 2'(i % 4);
            x.div = ratios[x.idx];
            x.err = 1'b0;
            x.tmo = 1'b0;
            exp_q.push_back(x);
        end
        mdl_div   = 32'd3;
        bus.i_Req = 4'b1111;
        for (int i = 0; i < 400 && exp_q.size() != 0; i++) tick(1);
        bus.i_Req = 4'b0000;
        check("t4_drained", 64'(exp_q.size()), 64'd0);

        // Stop divided clock.
        div_run = 1'b0;
        tick(2);
        bus.i_Div_Clk = 1'b0;
        tick(6);

        // Timeout commit, then zero ratio rejected.
        serve("t5_tmo",  4'b0010, 2'd1, 32'd6, 1'b0, 1'b1, int'(TIMEOUT) + 3, 1'b0);
        serve("t5_zero", 4'b0100, 2'd2, 32'd0, 1'b1, 1'b0, 2, 1'b0);

        // Abort in WAIT_EDGE.
        wait_idle("t6a");
        ratios[3] = 32'd9;
        drive_ratios();
        bus.i_Req = 4'b1000;
        tick(6);
        bus.i_Req = 4'b0000;
        tick(3);
        check("t6a_busy", 64'(bus.o_Busy), 64'd0);
        check("t6a_div",  64'(bus.o_Div),  64'(mdl_div));

        // Abort coincident with a detected edge.
        wait_idle("t6b");
        bus.i_Req = 4'b1000;
        tick(3);
        bus.i_Div_Clk = 1'b1;
        tick(3);
        bus.i_Req = 4'b0000;
        tick(3);
        check("t6b_busy", 64'(bus.o_Busy), 64'd0);
        check("t6b_div",  64'(bus.o_Div),  64'(mdl_div));
        bus.i_Div_Clk = 1'b0;
        tick(6);

        // Pointer unchanged by aborts: 3 wins over 0.
        ratios[0] = 32'd4;
        serve("t6c_ptr", 4'b1001, 2'd3, 32'd6, 1'b0, 1'b0, 3, 1'b0);

        // Async reset in the middle of WAIT_EDGE.
        wait_idle("t1b");
        ratios[1] = 32'd11;
        drive_ratios();
        bus.i_Req = 4'b0010;
        tick(6);
        rst_n = 1'b0;
        #1;
        check("t1b_async_rst", 64'({bus.o_Div, bus.o_Busy, bus.o_Gnt, bus.o_Timeout, bus.o_Err}),
              64'(rst_vec));
        bus.i_Req = 4'b0000;
        tick(2);
        rst_n   = 1'b1;
        mdl_div = 32'd1;
        tick(2);

        // Back to bypass after reset.
        serve("t1b_after", 4'b0001, 2'd0, 32'd5, 1'b0, 1'b0, 3, 1'b0);
        tick(10);
        check("final_queue", 64'(exp_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
